ysyx_22040127_mem_responder: RTL



---
 rtl/ysyx_22040127_mem_pkg.sv | 17 +
 rtl/ysyx_22040127_mem_array.sv | 40 ++++
 rtl/ysyx_22040127_mem_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040127_mem_pkg.sv
// Shared types and constants for the doubleword memory responder.
package ysyx_22040127_mem_pkg;

    // Width of the latency down-counter (LATENCY is at most 15).
    localparam int CNT_W  = 4;

    // One write strobe per byte of a 64-bit doubleword.
    localparam int STRB_W = 8;

    // Transaction FSM: one request outstanding at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ysyx_22040127_mem_array.sv
// 64-bit wide storage with byte-strobed synchronous write and registered read.
// Contents are never reset.
module ysyx_22040127_mem_array
    import ysyx_22040127_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [63:0]           wdata,
    input  logic [STRB_W-1:0]     wstrb,
    output logic [63:0]           rdata
);

    logic [63:0]       mem [0:(1<<DEPTH_LOG2)-1];
    logic [63:0]       rdata_reg;
    logic [STRB_W-1:0] lane_we;

    // Per-lane write enable: a lane is written only when its strobe is set.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        assign lane_we[gi] = we & wstrb[gi];
    end

    // Byte-lane writes and registered read share one clocked process.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (lane_we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/ysyx_22040127_mem_responder.sv
// Single-outstanding memory responder: accepts one doubleword request,
// commits it to the array after LATENCY-1 cycles, and presents the response
// one cycle later, holding it until the core takes it.
module ysyx_22040127_mem_responder
    import ysyx_22040127_mem_pkg::*;
#(
    parameter logic [63:0] BASE       = 64'h8000_0000,
    parameter int          DEPTH_LOG2 = 8,
    parameter int          LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [63:3]       addr_reg;
    logic              wen_reg;
    logic [63:0]       wdata_reg;
    logic [STRB_W-1:0] wstrb_reg;

    logic              rsp_valid_reg;
    logic [63:0]       rsp_rdata_reg;
    logic              rsp_err_reg;

    logic              accept;
    logic              enter_resp;
    logic              use_live;
    logic [63:3]       c_addr;
    logic              c_wen;
    logic [63:0]       c_wdata;
    logic [STRB_W-1:0] c_wstrb;
    logic              c_in_range;
    logic              mem_we;
    logic              mem_re;
    logic [63:0]       mem_rdata;
    logic              lat_in_range;
    logic              unused_addr_bits;

    // Doubleword access: the byte offset within the word carries no meaning.
    assign unused_addr_bits = ^req_addr[2:0];

    // Memory is size-aligned, so the range check is a compare of the high bits.
    function automatic logic in_range(input logic [63:3] a);
        in_range = (a[63:DEPTH_LOG2+3] == BASE[63:DEPTH_LOG2+3]);
    endfunction

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid && req_ready;

    // Next-state and counter logic; enter_resp marks the commit edge.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RESP;
                    cnt_next   = '0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_valid_reg && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture the request fields at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            wen_reg   <= 1'b0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else if (accept) begin
            addr_reg  <= req_addr[63:3];
            wen_reg   <= req_wen;
            wdata_reg <= req_wdata;
            wstrb_reg <= req_wstrb;
        end
    end

    // With LATENCY == 1 the commit edge is the accept edge itself, so the
    // live request must feed the array instead of the not-yet-latched copy.
    assign use_live   = (state_reg == IDLE);
    assign c_addr     = use_live ? req_addr[63:3] : addr_reg;
    assign c_wen      = use_live ? req_wen        : wen_reg;
    assign c_wdata    = use_live ? req_wdata      : wdata_reg;
    assign c_wstrb    = use_live ? req_wstrb      : wstrb_reg;
    assign c_in_range = in_range(c_addr);

    assign mem_we = enter_resp && c_wen && c_in_range;
    assign mem_re = enter_resp && !c_wen && c_in_range;

    ysyx_22040127_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (c_addr[DEPTH_LOG2+2:3]),
        .wdata (c_wdata),
        .wstrb (c_wstrb),
        .rdata (mem_rdata)
    );

    assign lat_in_range = in_range(addr_reg);

    // Response registers: loaded in the first RESP cycle once the array read
    // data is available, held until the handshake, then cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else if (state_reg == RESP && !rsp_valid_reg) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= !lat_in_range;
            rsp_rdata_reg <= (wen_reg || !lat_in_range) ? 64'd0 : mem_rdata;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
